adc_spi_responder: RTL

- SPI responder that emulates the MCP3204-class ADC on the MIKROE-340 board. This is the device end of the bus that our ADC controller drives.
- Receives the start bit and channel command on mosi, then returns a null bit followed by a DATA_W-bit sample on miso, MSB first.
- Used as the digital twin of the ADC. It lets controller logic be checked against a known-good peer, and a failing ADC be emulated, entirely on the FPGA.
- Runs on the 50 MHz system clock. sclk/cs_n/mosi are oversampled; they are never used as clocks.

---
 rtl/adc_spi_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// SPI device-side twin of an MCP3204-class ADC: takes start bit + command on mosi, returns null bit + sample on miso.
// Optional build macro ADC_RESP_LSB_TRAILER_EN adds the LSB-first echo after B0.
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   input  logic [DATA_W-1:0] sample_in,
   output logic              miso,
   output logic              miso_oe,
   output logic [2:0]        ch_sel,
   output logic              sgl_diff,
   output logic              sample_req,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(DATA_W + 4);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(3);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_START = 3'd1;
   localparam logic [2:0] ST_CMD        = 3'd2;
   localparam logic [2:0] ST_SAMPLE     = 3'd3;
   localparam logic [2:0] ST_NULL       = 3'd4;
   localparam logic [2:0] ST_DATA       = 3'd5;
   localparam logic [2:0] ST_TRAIL      = 3'd6;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_d;
   logic                   rise_evt;
   logic                   fall_evt;
   logic [2:0]             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      shift_reg;
   logic [2:0]             cmd_bits;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronizers plus a registered edge detector, so events land SYNC_STAGES+1 clk after the pin edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         rise_evt  <= 1'b0;
         fall_evt  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         rise_evt  <= sclk_s & ~sclk_d;
         fall_evt  <= ~sclk_s & sclk_d;
      end
   end

   assign miso_oe = (state == ST_SAMPLE) || (state == ST_NULL) ||
                    (state == ST_DATA)   || (state == ST_TRAIL);

   // cs_n high takes priority over any sclk event; DATA rotates the sample so TRAIL can echo it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         cmd_bits   <= '0;
         miso       <= 1'b0;
         ch_sel     <= '0;
         sgl_diff   <= 1'b0;
         sample_req <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sample_req <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (state != ST_IDLE && cs_s) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
            if (state == ST_TRAIL)
               frame_done <= 1'b1;
            else if (state != ST_WAIT_START)
               frame_err <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!cs_s)
                     state <= ST_WAIT_START;
               end
               ST_WAIT_START: begin
                  if (rise_evt && mosi_s) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (rise_evt) begin
                     cmd_bits <= {cmd_bits[1:0], mosi_s};
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == CMD_LAST) begin
                        sgl_diff   <= cmd_bits[2];
                        ch_sel     <= {cmd_bits[1:0], mosi_s};
                        sample_req <= 1'b1;
                        state      <= ST_SAMPLE;
                     end
                  end
               end
               ST_SAMPLE: begin
                  miso <= 1'b0;
                  if (fall_evt) begin
                     shift_reg <= sample_in;
                     state     <= ST_NULL;
                  end
               end
               ST_NULL: begin
                  if (fall_evt) begin
                     miso    <= 1'b0;
                     bit_cnt <= '0;
                     state   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (fall_evt) begin
                     miso      <= shift_reg[DATA_W-1];
                     shift_reg <= {shift_reg[DATA_W-2:0], shift_reg[DATA_W-1]};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_TRAIL;
                     end
                  end
               end
               ST_TRAIL: begin
                  if (fall_evt) begin
`ifdef ADC_RESP_LSB_TRAILER_EN
                     if (bit_cnt != DATA_LAST) begin
                        miso      <= shift_reg[1];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                     end else begin
                        miso <= 1'b0;
                     end
`else
                     miso <= 1'b0;
`endif
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
